life_scheduler: RTL and testbench

Control and timing block for the Game of Life datapath. It owns the game-rate and display-rate dividers and the run/pause/single-step/load mode FSM. It drives the LED matrix row scan. It issues step_game and load_seed pulses to the cell array only at display frame boundaries, so the cell state never changes mid-frame.

---
 rtl/life_pkg.sv | 14 +
 rtl/rate_divider.sv | 29 ++
 rtl/life_scheduler.sv | 138 +++++++++++++
 tb/tb_life_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and sizing helpers for the Game of Life scheduler.
package life_pkg;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Row index width; a single-row matrix still needs a 1-bit index.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Modulo-PERIOD counter producing a one-cycle tick in its last count.
module rate_divider #(
    parameter int PERIOD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/life_scheduler.sv
// Run/pause/step/load control and row scan for the Game of Life datapath.
// Generation updates are deferred to frame boundaries so a frame is never torn.
module life_scheduler
    import life_pkg::*;
#(
    parameter int N              = 8,
    parameter int GAME_PERIOD    = 4194304,
    parameter int DISPLAY_PERIOD = 1024,
    parameter int GEN_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_btn,
    input  logic                  step_btn,
    input  logic                  load_btn,
    output logic                  step_game,
    output logic                  load_seed,
    output logic [row_w(N)-1:0]   row_index,
    output logic [N-1:0]          row_onehot,
    output logic                  running,
    output logic                  overrun,
    output logic [GEN_W-1:0]      generation
);

    localparam int ROW_W = row_w(N);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    state_t           state;
    logic             run_q;
    logic             step_q;
    logic             load_q;
    logic             step_pending;
    logic             load_pending;
    logic             run_edge;
    logic             step_edge;
    logic             load_edge;
    logic             disp_tick;
    logic             game_tick;
    logic             game_clr;
    logic             frame_end;
    logic             step_set;
    logic [ROW_W-1:0] row_next;

    assign run_edge  = run_btn  & ~run_q;
    assign step_edge = step_btn & ~step_q;
    assign load_edge = load_btn & ~load_q;

    // The game divider only advances while running and restarts from zero on every entry.
    assign game_clr = (state != RUN) || load_edge;

    rate_divider #(.PERIOD(GAME_PERIOD)) u_game_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state == RUN),
        .clr  (game_clr),
        .tick (game_tick)
    );

    rate_divider #(.PERIOD(DISPLAY_PERIOD)) u_disp_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .clr  (1'b0),
        .tick (disp_tick)
    );

    assign frame_end = disp_tick && (row_index == LAST_ROW);
    assign row_next  = frame_end ? '0 : row_index + ROW_W'(1);

    // A step edge in the same cycle as a run edge belongs to the run transition, not a step.
    assign step_set = ((state == RUN) && game_tick) ||
                      ((state == PAUSED) && step_edge && !run_edge);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PAUSED;
            running      <= 1'b0;
            run_q        <= 1'b1;
            step_q       <= 1'b1;
            load_q       <= 1'b1;
            step_pending <= 1'b0;
            load_pending <= 1'b0;
            overrun      <= 1'b0;
            step_game    <= 1'b0;
            load_seed    <= 1'b0;
            generation   <= '0;
            row_index    <= '0;
            row_onehot   <= N'(1);
        end else begin
            run_q     <= run_btn;
            step_q    <= step_btn;
            load_q    <= load_btn;
            step_game <= 1'b0;
            load_seed <= 1'b0;

            if (load_edge) begin
                state   <= PAUSED;
                running <= 1'b0;
            end else if (run_edge) begin
                state   <= (state == PAUSED) ? RUN : PAUSED;
                running <= (state == PAUSED);
            end

            if (disp_tick) begin
                row_index  <= row_next;
                row_onehot <= N'(1) << row_next;
            end

            if (frame_end) begin
                if (load_pending) begin
                    load_seed  <= 1'b1;
                    generation <= '0;
                end else if (step_pending) begin
                    step_game  <= 1'b1;
                    generation <= generation + GEN_W'(1);
                end
            end

            // New requests take precedence over consumption so nothing raised at a boundary is lost.
            load_pending <= load_edge || (load_pending && !frame_end);

            if (load_edge) begin
                step_pending <= 1'b0;
            end else if (step_set) begin
                step_pending <= 1'b1;
            end else if (frame_end && !load_pending) begin
                step_pending <= 1'b0;
            end

            if (load_edge) begin
                overrun <= 1'b0;
            end else if (game_tick && step_pending) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_life_scheduler.sv
// Scoreboard bench for life_scheduler: expected pulses are queued by the stimulus
// and matched by a monitor as the DUT emits step_game/load_seed.
module tb_life_scheduler;

    localparam int N     = 4;
    localparam int GP    = 5;
    localparam int DP    = 2;
    localparam int GEN_W = 16;

    typedef struct {
        bit is_load;
        int cyc;
        int gen;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run_btn = 1'b1;
    logic             step_btn = 1'b0;
    logic             load_btn = 1'b0;
    logic             step_game;
    logic             load_seed;
    logic [1:0]       row_index;
    logic [N-1:0]     row_onehot;
    logic             running;
    logic             overrun;
    logic [GEN_W-1:0] generation;

    int   cyc;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;

    life_scheduler #(
        .N              (N),
        .GAME_PERIOD    (GP),
        .DISPLAY_PERIOD (DP),
        .GEN_W          (GEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .load_btn   (load_btn),
        .step_game  (step_game),
        .load_seed  (load_seed),
        .row_index  (row_index),
        .row_onehot (row_onehot),
        .running    (running),
        .overrun    (overrun),
        .generation (generation)
    );

    always #5 clk = ~clk;

    // Edge count since reset release: after the k-th edge, cyc == k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_pulse(input bit is_load, input int at, input int gen);
        exp_t x;
        x.is_load = is_load;
        x.cyc     = at;
        x.gen     = gen;
        exp_q.push_back(x);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (step_game || load_seed)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: step_game=%0b load_seed=%0b at cyc %0d, none expected",
                         step_game, load_seed, cyc);
            end else begin
                e = exp_q.pop_front();
                if (load_seed !== e.is_load || step_game !== !e.is_load || cyc != e.cyc ||
                    generation != GEN_W'(e.gen) || row_onehot != 4'b0001) begin
                    errors++;
                    $display("FAIL pulse: got load=%0b step=%0b cyc=%0d gen=%0d rows=%b, expected load=%0b step=%0b cyc=%0d gen=%0d rows=0001",
                             load_seed, step_game, cyc, generation, row_onehot,
                             e.is_load, !e.is_load, e.cyc, e.gen);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with run_btn held high; release must not create a run edge.
        #32 rst = 1'b0;
        #1;
        check("rst_running",    32'(running),    0);
        check("rst_overrun",    32'(overrun),    0);
        check("rst_generation", 32'(generation), 0);
        check("rst_row_onehot", 32'(row_onehot), 1);
        check("rst_step_game",  32'(step_game),  0);
        check("rst_load_seed",  32'(load_seed),  0);

        wait_cyc(4);
        run_btn = 1'b0;
        wait_cyc(32);
        check("held_btn_running", 32'(running), 0);

        // Row scan while paused: each row lasts DP cycles.
        for (int k = 33; k <= 48; k++) begin
            wait_cyc(k);
            check("scan_onehot", 32'(row_onehot), 32'(1 << ((k / 2) % 4)));
            check("scan_index",  32'(row_index),  32'((k / 2) % 4));
        end

        // Two step edges in one frame collapse into a single step at the boundary.
        wait_cyc(50);
        step_btn = 1'b1;
        expect_pulse(1'b0, 56, 1);
        wait_cyc(51); step_btn = 1'b0;
        wait_cyc(52); step_btn = 1'b1;
        wait_cyc(53); step_btn = 1'b0;
        wait_cyc(64);
        check("single_step_gen",     32'(generation), 1);
        check("single_step_running", 32'(running),    0);

        // Run: ticks at 70,75,80,85,90,95,100; frames end at 72,80,88,96.
        run_btn = 1'b1;
        expect_pulse(1'b0, 72, 2);
        expect_pulse(1'b0, 80, 3);
        expect_pulse(1'b0, 88, 4);
        expect_pulse(1'b0, 96, 5);
        wait_cyc(65);
        check("run_running", 32'(running), 1);
        wait_cyc(66); run_btn = 1'b0;
        wait_cyc(79);
        check("run_overrun_before", 32'(overrun), 0);
        wait_cyc(88);
        check("run_overrun_after", 32'(overrun), 1);
        wait_cyc(100);
        check("run_gen", 32'(generation), 5);

        // Load with a step pending; a later paused step waits behind the load.
        load_btn = 1'b1;
        expect_pulse(1'b1, 104, 0);
        expect_pulse(1'b0, 112, 1);
        wait_cyc(101);
        check("load_running", 32'(running), 0);
        check("load_overrun", 32'(overrun), 0);
        load_btn = 1'b0;
        wait_cyc(102); step_btn = 1'b1;
        wait_cyc(103); step_btn = 1'b0;

        // Simultaneous run and step edges while paused: only the run takes effect.
        wait_cyc(114);
        run_btn  = 1'b1;
        step_btn = 1'b1;
        expect_pulse(1'b0, 128, 2);
        wait_cyc(115);
        run_btn  = 1'b0;
        step_btn = 1'b0;
        check("runstep_running", 32'(running), 1);
        wait_cyc(119);
        check("runstep_overrun_before", 32'(overrun), 0);
        wait_cyc(126);
        check("runstep_overrun_after", 32'(overrun), 1);

        wait_cyc(130);
        check("all_pulses_seen", 32'(exp_q.size()), 0);

        // Asynchronous reset between edges while running.
        #2 rst = 1'b1;
        #1;
        check("arst_running",    32'(running),    0);
        check("arst_overrun",    32'(overrun),    0);
        check("arst_generation", 32'(generation), 0);
        check("arst_row_index",  32'(row_index),  0);
        check("arst_row_onehot", 32'(row_onehot), 1);
        check("arst_step_game",  32'(step_game),  0);
        check("arst_load_seed",  32'(load_seed),  0);

        #20 rst = 1'b0;
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
